seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl_if.sv | 24 ++
 rtl/seg_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Value-source / display-side bundle for seg_scan_ctrl: load handshake plus the
// scan outputs feeding the segment lookup and the anode pins.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic                    load_ready;
  logic [1:0]              ref_clk;
  logic [3:0]              digit_val;
  logic [NUM_DIGITS-1:0]   anodes_n;
  logic                    frame_done;

  modport master (
    output enable, load, load_data,
    input  load_ready, ref_clk, digit_val, anodes_n, frame_done
  );

  modport slave (
    input  enable, load, load_data,
    output load_ready, ref_clk, digit_val, anodes_n, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a frame-synchronous double buffer.
// Optional macro LEADING_ZERO_BLANK_EN keeps leading-zero digits dark.
module seg_scan_ctrl #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int NUM_DIGITS   = 4
) (
  input logic           clk,
  input logic           rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]         SLOT_LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]         BLANK_LAST = PW'(BLANK_CYCLES - 1);
  localparam logic [1:0]            REF_LAST   = 2'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DARK       = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [PW-1:0]           r_presc;
  logic [1:0]              r_ref_clk;
  logic [3:0]              r_digit_val;
  logic [NUM_DIGITS-1:0]   r_anodes_n;
  logic                    r_frame_done;
  logic                    r_load_ready;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [4*NUM_DIGITS-1:0] r_shadow;

  logic [NUM_DIGITS-1:0]   w_lit;
  logic [NUM_DIGITS-1:0]   w_show_anodes_n;
  logic [1:0]              w_ref_inc;

  assign w_ref_inc = r_ref_clk + 2'd1;

  // Anode pattern loaded on BLANK->SHOW; the active register cannot change inside a slot.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
`ifdef LEADING_ZERO_BLANK_EN
    if (gi == 0) begin : g_first
      assign w_lit[gi] = 1'b1;
    end else begin : g_upper
      assign w_lit[gi] = |r_active[4*NUM_DIGITS-1:4*gi];
    end
`else
    assign w_lit[gi] = 1'b1;
`endif
    assign w_show_anodes_n[gi] = ~(w_lit[gi] && (r_ref_clk == 2'(gi)));
  end

  function automatic logic [3:0] nibble_at(input logic [4*NUM_DIGITS-1:0] v,
                                           input logic [1:0] k);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (k == 2'(i)) n = v[4*i +: 4];
    end
    return n;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_presc      <= '0;
      r_ref_clk    <= '0;
      r_digit_val  <= '0;
      r_anodes_n   <= DARK;
      r_frame_done <= 1'b0;
      r_load_ready <= 1'b1;
      r_pending    <= 1'b0;
      r_active     <= '0;
      r_shadow     <= '0;
    end else begin
      r_frame_done <= 1'b0;

      // load_ready trails pending by one cycle, so a commit edge never sees a transfer.
      if (bus.load && r_load_ready) begin
        r_shadow     <= bus.load_data;
        r_pending    <= 1'b1;
        r_load_ready <= 1'b0;
      end else begin
        r_load_ready <= ~r_pending;
      end

      case (r_state)
        IDLE: begin
          r_presc    <= '0;
          r_ref_clk  <= '0;
          r_anodes_n <= DARK;
          if (r_pending) begin
            r_active    <= r_shadow;
            r_pending   <= 1'b0;
            r_digit_val <= r_shadow[3:0];
          end else begin
            r_digit_val <= r_active[3:0];
          end
          if (bus.enable) r_state <= BLANK;
        end

        BLANK: begin
          if (!bus.enable) begin
            r_state     <= IDLE;
            r_presc     <= '0;
            r_ref_clk   <= '0;
            r_anodes_n  <= DARK;
            r_digit_val <= r_active[3:0];
          end else begin
            r_presc <= r_presc + PW'(1);
            if (r_presc == BLANK_LAST) begin
              r_state    <= SHOW;
              r_anodes_n <= w_show_anodes_n;
            end
          end
        end

        SHOW: begin
          if (!bus.enable) begin
            r_state     <= IDLE;
            r_presc     <= '0;
            r_ref_clk   <= '0;
            r_anodes_n  <= DARK;
            r_digit_val <= r_active[3:0];
          end else if (r_presc == SLOT_LAST) begin
            r_state    <= BLANK;
            r_presc    <= '0;
            r_anodes_n <= DARK;
            if (r_ref_clk == REF_LAST) begin
              // Frame boundary: the only place a running display swaps buffers.
              r_ref_clk    <= '0;
              r_frame_done <= 1'b1;
              if (r_pending) begin
                r_active    <= r_shadow;
                r_pending   <= 1'b0;
                r_digit_val <= r_shadow[3:0];
              end else begin
                r_digit_val <= r_active[3:0];
              end
            end else begin
              r_ref_clk   <= w_ref_inc;
              r_digit_val <= nibble_at(r_active, w_ref_inc);
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end

        default: begin
          r_state    <= IDLE;
          r_presc    <= '0;
          r_ref_clk  <= '0;
          r_anodes_n <= DARK;
        end
      endcase
    end
  end

  assign bus.load_ready = r_load_ready;
  assign bus.ref_clk    = r_ref_clk;
  assign bus.digit_val  = r_digit_val;
  assign bus.anodes_n   = r_anodes_n;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (CLK_DIV=8, BLANK_CYCLES=2, NUM_DIGITS=4).
// Build with +define+LEADING_ZERO_BLANK_EN to exercise leading-zero blanking.
module tb_seg_scan_ctrl;

  localparam int CLK_DIV      = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int NUM_DIGITS   = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [15:0] exp_q[$];

  seg_scan_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

  seg_scan_ctrl #(
    .CLK_DIV     (CLK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .NUM_DIGITS  (NUM_DIGITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.load = 1'b0;
    bus.load_data = '0;
    repeat (3) tick();
    checks++; if (bus.anodes_n !== 4'hF) begin failures++; $display("FAIL rst_anodes got=%b exp=1111", bus.anodes_n); end
    checks++; if (bus.ref_clk !== 2'd0) begin failures++; $display("FAIL rst_ref got=%0d exp=0", bus.ref_clk); end
    checks++; if (bus.digit_val !== 4'h0) begin failures++; $display("FAIL rst_digit got=%h exp=0", bus.digit_val); end
    checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.load_ready); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL rst_fd got=%b exp=0", bus.frame_done); end
    rst = 1'b0;
    tick();
    checks++; if (bus.anodes_n !== 4'hF) begin failures++; $display("FAIL idle_anodes got=%b exp=1111", bus.anodes_n); end
    $display("txn reset released");
  endtask

  task automatic test_scan();
    int s, pos;
    logic [3:0] exp_an;
    logic       exp_fd;
    bus.enable = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      tick();
      s = (c - 1) / CLK_DIV;
      pos = (c - 1) % CLK_DIV;
      exp_an = (pos < BLANK_CYCLES) ? 4'hF : ~(4'b0001 << (s % NUM_DIGITS));
      exp_fd = (pos == 0) && (s % NUM_DIGITS == 0) && (s > 0);
      checks++; if (bus.anodes_n !== exp_an) begin failures++; $display("FAIL scan_anodes c=%0d got=%b exp=%b", c, bus.anodes_n, exp_an); end
      checks++; if (bus.ref_clk !== 2'(s % NUM_DIGITS)) begin failures++; $display("FAIL scan_ref c=%0d got=%0d exp=%0d", c, bus.ref_clk, s % NUM_DIGITS); end
      checks++; if (bus.frame_done !== exp_fd) begin failures++; $display("FAIL scan_fd c=%0d got=%b exp=%b", c, bus.frame_done, exp_fd); end
      checks++; if (bus.digit_val !== 4'h0) begin failures++; $display("FAIL scan_digit c=%0d got=%h exp=0", c, bus.digit_val); end
    end
    $display("txn scan 70 cycles");
  endtask

  task automatic test_load();
    bit got;
    logic [15:0] exp;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin tick(); got = (bus.frame_done === 1'b1); end
    checks++; if (!got) begin failures++; $display("FAIL load_sync got=no_frame_done exp=frame_done"); end
    repeat (5) tick();
    checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL load_ready_pre got=%b exp=1", bus.load_ready); end
    bus.load = 1'b1;
    bus.load_data = 16'h1234;
    exp_q.push_back(16'h1234);
    tick();
    $display("txn load data=1234");
    checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL load_ready_busy got=%b exp=0", bus.load_ready); end
    bus.load_data = 16'hABCD;
    tick();
    $display("txn load data=abcd while busy");
    bus.load = 1'b0;
    bus.load_data = '0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (bus.frame_done === 1'b1) got = 1;
      else begin
        checks++; if (bus.digit_val !== 4'h0) begin failures++; $display("FAIL load_hold_old got=%h exp=0", bus.digit_val); end
      end
    end
    checks++; if (!got) begin failures++; $display("FAIL load_commit got=no_frame_done exp=frame_done"); end
    exp = exp_q.pop_front();
    checks++; if (bus.digit_val !== exp[3:0]) begin failures++; $display("FAIL commit_digit got=%h exp=%h", bus.digit_val, exp[3:0]); end
    checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL commit_ready got=%b exp=0", bus.load_ready); end
    tick();
    checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL ready_return got=%b exp=1", bus.load_ready); end
    tick();
    for (int k = 0; k < NUM_DIGITS; k++) begin
      checks++; if (bus.ref_clk !== 2'(k)) begin failures++; $display("FAIL frame_ref got=%0d exp=%0d", bus.ref_clk, k); end
      checks++; if (bus.digit_val !== exp[4*k +: 4]) begin failures++; $display("FAIL frame_digit k=%0d got=%h exp=%h", k, bus.digit_val, exp[4*k +: 4]); end
      checks++; if (bus.anodes_n !== ~(4'b0001 << k)) begin failures++; $display("FAIL frame_anodes k=%0d got=%b exp=%b", k, bus.anodes_n, ~(4'b0001 << k)); end
      repeat (CLK_DIV) tick();
    end
  endtask

  task automatic test_enable_drop();
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin tick(); got = (bus.frame_done === 1'b1); end
    checks++; if (!got) begin failures++; $display("FAIL drop_sync got=no_frame_done exp=frame_done"); end
    repeat (2 * CLK_DIV + 4) tick();
    checks++; if (bus.ref_clk !== 2'd2) begin failures++; $display("FAIL drop_pre_ref got=%0d exp=2", bus.ref_clk); end
    checks++; if (bus.anodes_n !== 4'b1011) begin failures++; $display("FAIL drop_pre_anodes got=%b exp=1011", bus.anodes_n); end
    bus.enable = 1'b0;
    tick();
    $display("txn enable drop in show digit 2");
    checks++; if (bus.anodes_n !== 4'hF) begin failures++; $display("FAIL drop_anodes got=%b exp=1111", bus.anodes_n); end
    checks++; if (bus.ref_clk !== 2'd0) begin failures++; $display("FAIL drop_ref got=%0d exp=0", bus.ref_clk); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL drop_fd got=%b exp=0", bus.frame_done); end
    checks++; if (bus.digit_val !== 4'h4) begin failures++; $display("FAIL drop_digit got=%h exp=4", bus.digit_val); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.frame_done !== 1'b0 || bus.anodes_n !== 4'hF) begin failures++; $display("FAIL idle_quiet got=fd%b/%b exp=fd0/1111", bus.frame_done, bus.anodes_n); end
    end
    bus.enable = 1'b1;
    tick();
    checks++; if (bus.anodes_n !== 4'hF || bus.ref_clk !== 2'd0) begin failures++; $display("FAIL restart_blank1 got=%b/%0d exp=1111/0", bus.anodes_n, bus.ref_clk); end
    tick();
    checks++; if (bus.anodes_n !== 4'hF) begin failures++; $display("FAIL restart_blank2 got=%b exp=1111", bus.anodes_n); end
    tick();
    checks++; if (bus.anodes_n !== 4'b1110 || bus.digit_val !== 4'h4) begin failures++; $display("FAIL restart_show got=%b/%h exp=1110/4", bus.anodes_n, bus.digit_val); end
    $display("txn re-enable");
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    bus.enable = 1'b0;
    tick();
    checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_pre got=%b exp=1", bus.load_ready); end
    bus.load = 1'b1;
    bus.load_data = 16'h9F0E;
    exp_q.push_back(16'h9F0E);
    tick();
    $display("txn idle load data=9f0e");
    bus.load = 1'b0;
    checks++; if (bus.load_ready !== 1'b0 || bus.digit_val !== 4'h4) begin failures++; $display("FAIL b2b_accept got=%b/%h exp=0/4", bus.load_ready, bus.digit_val); end
    tick();
    exp = exp_q.pop_front();
    checks++; if (bus.digit_val !== exp[3:0]) begin failures++; $display("FAIL b2b_commit1 got=%h exp=%h", bus.digit_val, exp[3:0]); end
    checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_commit got=%b exp=0", bus.load_ready); end
    tick();
    checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_back got=%b exp=1", bus.load_ready); end
    bus.load = 1'b1;
    bus.load_data = 16'h2222;
    exp_q.push_back(16'h2222);
    tick();
    $display("txn idle load data=2222");
    bus.load = 1'b0;
    checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept2 got=%b exp=0", bus.load_ready); end
    tick();
    exp = exp_q.pop_front();
    checks++; if (bus.digit_val !== exp[3:0]) begin failures++; $display("FAIL b2b_commit2 got=%h exp=%h", bus.digit_val, exp[3:0]); end
    tick();
    checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_back2 got=%b exp=1", bus.load_ready); end
  endtask

  task automatic test_async_reset();
    bit got;
    bus.enable = 1'b1;
    bus.load = 1'b1;
    bus.load_data = 16'h5678;
    exp_q.push_back(16'h5678);
    tick();
    $display("txn load data=5678 then async reset");
    bus.load = 1'b0;
    checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL ar_pending got=%b exp=0", bus.load_ready); end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin tick(); got = (bus.anodes_n !== 4'hF); end
    checks++; if (!got || bus.digit_val !== 4'h2) begin failures++; $display("FAIL ar_show got=%b/%h exp=lit/2", bus.anodes_n, bus.digit_val); end
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    checks++; if (bus.anodes_n !== 4'hF) begin failures++; $display("FAIL ar_anodes got=%b exp=1111", bus.anodes_n); end
    checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b exp=1", bus.load_ready); end
    checks++; if (bus.digit_val !== 4'h0) begin failures++; $display("FAIL ar_digit got=%h exp=0", bus.digit_val); end
    checks++; if (bus.ref_clk !== 2'd0) begin failures++; $display("FAIL ar_ref got=%0d exp=0", bus.ref_clk); end
    @(negedge clk);
    rst = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin tick(); got = (bus.frame_done === 1'b1); end
    checks++; if (!got) begin failures++; $display("FAIL ar_frame got=no_frame_done exp=frame_done"); end
    checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL ar_no_commit_ready got=%b exp=1", bus.load_ready); end
    repeat (BLANK_CYCLES) tick();
    for (int k = 0; k < NUM_DIGITS; k++) begin
      checks++; if (bus.digit_val !== 4'h0) begin failures++; $display("FAIL ar_lost k=%0d got=%h exp=0", k, bus.digit_val); end
      repeat (CLK_DIV) tick();
    end
  endtask

  task automatic test_leading_zero();
    bit got;
    bit lit;
    logic [15:0] exp;
    logic [15:0] vals [2];
    logic [3:0]  exp_an;
    vals[0] = 16'h0007;
    vals[1] = 16'h0000;
    for (int v = 0; v < 2; v++) begin
      checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL lz_ready got=%b exp=1", bus.load_ready); end
      bus.load = 1'b1;
      bus.load_data = vals[v];
      exp_q.push_back(vals[v]);
      tick();
      $display("txn load data=%h", vals[v]);
      bus.load = 1'b0;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin tick(); got = (bus.frame_done === 1'b1); end
      checks++; if (!got) begin failures++; $display("FAIL lz_frame got=no_frame_done exp=frame_done"); end
      exp = exp_q.pop_front();
      repeat (BLANK_CYCLES) tick();
      for (int k = 0; k < NUM_DIGITS; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
        lit = (k == 0) || ((exp >> (4 * k)) != 16'h0);
`else
        lit = 1'b1;
`endif
        exp_an = lit ? ~(4'b0001 << k) : 4'hF;
        checks++; if (bus.anodes_n !== exp_an) begin failures++; $display("FAIL lz_anodes v=%h k=%0d got=%b exp=%b", exp, k, bus.anodes_n, exp_an); end
        checks++; if (bus.digit_val !== exp[4*k +: 4]) begin failures++; $display("FAIL lz_digit v=%h k=%0d got=%h exp=%h", exp, k, bus.digit_val, exp[4*k +: 4]); end
        repeat (CLK_DIV) tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_enable_drop();
    test_back_to_back();
    test_async_reset();
    test_leading_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
